csr_regfile: RTL

//  Privileged CSR state for the RV64 core: consumes the 6-bit CSR control word and zimm from the CSR decoder.

---
 rtl/csr_pkg.sv | 70 +++++++
 rtl/csr_regfile_alu.sv | 35 +++
 rtl/csr_regfile.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : csr_pkg
// Desc   : Shared CSR addresses, mstatus layout, control-word fields and codes.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
package csr_pkg;

  localparam logic [11:0] c_addr_sstatus  = 12'h100;
  localparam logic [11:0] c_addr_stvec    = 12'h105;
  localparam logic [11:0] c_addr_sscratch = 12'h140;
  localparam logic [11:0] c_addr_sepc     = 12'h141;
  localparam logic [11:0] c_addr_scause   = 12'h142;
  localparam logic [11:0] c_addr_mstatus  = 12'h300;
  localparam logic [11:0] c_addr_mtvec    = 12'h305;
  localparam logic [11:0] c_addr_mscratch = 12'h340;
  localparam logic [11:0] c_addr_mepc     = 12'h341;
  localparam logic [11:0] c_addr_mcause   = 12'h342;
  localparam logic [11:0] c_addr_mtval    = 12'h343;
  localparam logic [11:0] c_addr_mcycle   = 12'hB00;
  localparam logic [11:0] c_addr_minstret = 12'hB02;
  localparam logic [11:0] c_addr_mhartid  = 12'hF14;

  localparam int c_mst_w      = 13;
  localparam int c_mst_sie    = 1;
  localparam int c_mst_mie    = 3;
  localparam int c_mst_spie   = 5;
  localparam int c_mst_mpie   = 7;
  localparam int c_mst_spp    = 8;
  localparam int c_mst_mpp_lo = 11;
  localparam int c_mst_mpp_hi = 12;

  localparam logic [c_mst_w-1:0] c_mstatus_wmask = 13'h19AA;
  localparam logic [c_mst_w-1:0] c_sstatus_mask  = 13'h0122;

  localparam int c_sign_we   = 5;
  localparam int c_sign_mret = 4;
  localparam int c_sign_sret = 3;
  localparam int c_sign_imm  = 2;

  typedef enum logic [1:0] {
    c_op_write = 2'b00,
    c_op_set   = 2'b01,
    c_op_clear = 2'b10,
    c_op_none  = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    c_priv_u = 2'd0,
    c_priv_s = 2'd1,
    c_priv_m = 2'd3
  } priv_e;

  localparam logic [7:0] c_cause_illegal = 8'd2;
  localparam logic [7:0] c_cause_ecall_u = 8'd8;
  localparam logic [7:0] c_cause_ecall_s = 8'd9;
  localparam logic [7:0] c_cause_ecall_m = 8'd11;

  // MPP has no H-mode encoding here, so the reserved value 2 collapses to U.
  function automatic logic [c_mst_w-1:0] mstatus_warl(input logic [c_mst_w-1:0] v);
    logic [c_mst_w-1:0] r;
    r = v & c_mstatus_wmask;
    if (r[c_mst_mpp_hi:c_mst_mpp_lo] == 2'b10) begin
      r[c_mst_mpp_hi:c_mst_mpp_lo] = 2'b00;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_regfile_alu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : csr_alu
// Desc   : Combinational CSR read-modify-write value (write / set / clear).
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module csr_alu
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [1:0]      i_op,
  input  logic            i_use_imm,
  input  logic [XLEN-1:0] i_zimm,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_old,
  output logic [XLEN-1:0] o_result
);

  logic [XLEN-1:0] w_operand;

  assign w_operand = i_use_imm ? i_zimm : i_rs1;

  always_comb begin
    o_result = i_old;
    case (csr_op_e'(i_op))
      c_op_write: o_result = w_operand;
      c_op_set:   o_result = i_old | w_operand;
      c_op_clear: o_result = i_old & ~w_operand;
      default:    o_result = i_old;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/csr_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : csr_regfile
// Desc   : RV64 privileged CSR state: CSR ops, traps, xRET, privilege, counters.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module csr_regfile
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_TVEC = '0,
  parameter logic [XLEN-1:0] HART_ID    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_valid,
  input  logic [5:0]      sign,
  input  logic [XLEN-1:0] data,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] pc,
  input  logic            retire,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_tval,
  output logic [XLEN-1:0] csr_rdata,
  output logic            illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [1:0]      priv
);

  localparam logic [XLEN-1:0] c_align_mask = ~XLEN'(3);

  priv_e              r_priv;
  logic [c_mst_w-1:0] r_mstatus;
  logic [XLEN-1:0]    r_mtvec;
  logic [XLEN-1:0]    r_mscratch;
  logic [XLEN-1:0]    r_mepc;
  logic [XLEN-1:0]    r_mcause;
  logic [XLEN-1:0]    r_mtval;
  logic [XLEN-1:0]    r_stvec;
  logic [XLEN-1:0]    r_sscratch;
  logic [XLEN-1:0]    r_sepc;
  logic [XLEN-1:0]    r_scause;
  logic [XLEN-1:0]    r_mcycle;
  logic [XLEN-1:0]    r_minstret;
  logic               r_redirect_valid;
  logic [XLEN-1:0]    r_redirect_pc;

  logic               w_we;
  logic               w_mret;
  logic               w_sret;
  logic               w_xret;
  logic               w_hit;
  logic               w_illegal;
  logic               w_trap;
  logic               w_do_mret;
  logic               w_do_sret;
  logic               w_do_write;
  logic [XLEN-1:0]    w_rdata;
  logic [XLEN-1:0]    w_wdata;
  logic [XLEN-1:0]    w_wdata_al;
  logic [c_mst_w-1:0] w_mst_wr;
  logic [c_mst_w-1:0] w_sst_wr;
  logic [XLEN-1:0]    w_trap_cause;
  logic [XLEN-1:0]    w_trap_tval;

  assign w_we   = sign[c_sign_we];
  assign w_mret = sign[c_sign_mret];
  assign w_sret = sign[c_sign_sret];
  assign w_xret = w_mret | w_sret;

  always_comb begin
    w_rdata = '0;
    w_hit   = 1'b1;
    case (csr_addr)
      c_addr_mstatus:  w_rdata = XLEN'(r_mstatus);
      c_addr_sstatus:  w_rdata = XLEN'(r_mstatus & c_sstatus_mask);
      c_addr_mtvec:    w_rdata = r_mtvec;
      c_addr_mscratch: w_rdata = r_mscratch;
      c_addr_mepc:     w_rdata = r_mepc;
      c_addr_mcause:   w_rdata = r_mcause;
      c_addr_mtval:    w_rdata = r_mtval;
      c_addr_stvec:    w_rdata = r_stvec;
      c_addr_sscratch: w_rdata = r_sscratch;
      c_addr_sepc:     w_rdata = r_sepc;
      c_addr_scause:   w_rdata = r_scause;
      c_addr_mcycle:   w_rdata = r_mcycle;
      c_addr_minstret: w_rdata = r_minstret;
      c_addr_mhartid:  w_rdata = HART_ID;
      default:         w_hit   = 1'b0;
    endcase
  end

  // xRET encodings carry no CSR address, so address checks apply to CSR ops only.
  always_comb begin
    w_illegal = 1'b0;
    if (csr_valid) begin
      if (w_mret) begin
        w_illegal = (r_priv != c_priv_m);
      end else if (w_sret) begin
        w_illegal = (r_priv == c_priv_u);
      end else begin
        w_illegal = !w_hit
                 || (w_we && (csr_addr[11:10] == 2'b11))
                 || (2'(r_priv) < csr_addr[9:8]);
      end
    end
  end

  assign w_trap     = trap_valid | w_illegal;
  assign w_do_mret  = csr_valid & w_mret & ~w_trap;
  assign w_do_sret  = csr_valid & w_sret & ~w_mret & ~w_trap;
  assign w_do_write = csr_valid & w_we & ~w_xret & ~w_trap
                    & (sign[1:0] != c_op_none);

  csr_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .i_op      (sign[1:0]),
    .i_use_imm (sign[c_sign_imm]),
    .i_zimm    (data),
    .i_rs1     (rs1_data),
    .i_old     (w_rdata),
    .o_result  (w_wdata)
  );

  assign w_wdata_al   = w_wdata & c_align_mask;
  assign w_mst_wr     = mstatus_warl(w_wdata[c_mst_w-1:0]);
  assign w_sst_wr     = (r_mstatus & ~c_sstatus_mask) | (w_wdata[c_mst_w-1:0] & c_sstatus_mask);
  assign w_trap_cause = trap_valid ? trap_cause : XLEN'(c_cause_illegal);
  assign w_trap_tval  = trap_valid ? trap_tval : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_priv           <= c_priv_m;
      r_mstatus        <= '0;
      r_mtvec          <= RESET_TVEC;
      r_mscratch       <= '0;
      r_mepc           <= '0;
      r_mcause         <= '0;
      r_mtval          <= '0;
      r_stvec          <= '0;
      r_sscratch       <= '0;
      r_sepc           <= '0;
      r_scause         <= '0;
      r_mcycle         <= '0;
      r_minstret       <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= 1'b0;
      r_mcycle         <= r_mcycle + XLEN'(1);
      r_minstret       <= r_minstret + XLEN'(retire);
      if (w_trap) begin
        r_mepc                               <= pc & c_align_mask;
        r_mcause                             <= w_trap_cause;
        r_mtval                              <= w_trap_tval;
        r_mstatus[c_mst_mpie]                <= r_mstatus[c_mst_mie];
        r_mstatus[c_mst_mie]                 <= 1'b0;
        r_mstatus[c_mst_mpp_hi:c_mst_mpp_lo] <= r_priv;
        r_priv                               <= c_priv_m;
        r_redirect_valid                     <= 1'b1;
        r_redirect_pc                        <= r_mtvec;
      end else if (w_do_mret) begin
        r_priv                               <= priv_e'(r_mstatus[c_mst_mpp_hi:c_mst_mpp_lo]);
        r_mstatus[c_mst_mie]                 <= r_mstatus[c_mst_mpie];
        r_mstatus[c_mst_mpie]                <= 1'b1;
        r_mstatus[c_mst_mpp_hi:c_mst_mpp_lo] <= 2'b00;
        r_redirect_valid                     <= 1'b1;
        r_redirect_pc                        <= r_mepc;
      end else if (w_do_sret) begin
        r_priv                <= priv_e'({1'b0, r_mstatus[c_mst_spp]});
        r_mstatus[c_mst_sie]  <= r_mstatus[c_mst_spie];
        r_mstatus[c_mst_spie] <= 1'b1;
        r_mstatus[c_mst_spp]  <= 1'b0;
        r_redirect_valid      <= 1'b1;
        r_redirect_pc         <= r_sepc;
      end else if (w_do_write) begin
        // Counter writes override the free-running increment above.
        case (csr_addr)
          c_addr_mstatus:  r_mstatus  <= w_mst_wr;
          c_addr_sstatus:  r_mstatus  <= w_sst_wr;
          c_addr_mtvec:    r_mtvec    <= w_wdata_al;
          c_addr_mscratch: r_mscratch <= w_wdata;
          c_addr_mepc:     r_mepc     <= w_wdata_al;
          c_addr_mcause:   r_mcause   <= w_wdata;
          c_addr_mtval:    r_mtval    <= w_wdata;
          c_addr_stvec:    r_stvec    <= w_wdata_al;
          c_addr_sscratch: r_sscratch <= w_wdata;
          c_addr_sepc:     r_sepc     <= w_wdata_al;
          c_addr_scause:   r_scause   <= w_wdata;
          c_addr_mcycle:   r_mcycle   <= w_wdata;
          c_addr_minstret: r_minstret <= w_wdata;
          default:         ;
        endcase
      end
    end
  end

  assign csr_rdata      = w_rdata;
  assign illegal        = w_illegal;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign priv           = r_priv;

endmodule
`default_nettype wire
